// File: rtl/soc_sram_pkg.sv
// Shared types and constants for the asynchronous-SRAM controller.
package soc_sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_WR      = 3'd2,
    ST_WR_HOLD = 3'd3,
    ST_TURN    = 3'd4
  } state_e;

  // Counter has to hold a reload of up to 15 and a nominal count of 16.
  localparam int CNT_W    = 5;
  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 16;
  localparam int TURN_MAX = 15;

  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/soc_sram_ctrl_v2.sv
// Valid/ready request port to asynchronous SRAM; every strobe, address and data pin
// comes from a flop, and each access returns a single-cycle response.
module soc_sram_ctrl_v2
  import soc_sram_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  parameter int TURN    = 1,
  localparam int BE_W   = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BE_W-1:0]   req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_A,
  output logic              mem_CEN,
  output logic              mem_OEN,
  output logic              mem_WEN,
  output logic [BE_W-1:0]   mem_BEN,
  inout  wire  [DATA_W-1:0] mem_D
);

  if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_chk_dw
    $error("soc_sram_ctrl_v2: DATA_W must be a non-zero multiple of 8");
  end
  if (RD_WAIT < WAIT_MIN || RD_WAIT > WAIT_MAX) begin : g_chk_rd
    $error("soc_sram_ctrl_v2: RD_WAIT out of range");
  end
  if (WR_WAIT < WAIT_MIN || WR_WAIT > WAIT_MAX) begin : g_chk_wr
    $error("soc_sram_ctrl_v2: WR_WAIT out of range");
  end
  if (TURN < 0 || TURN > TURN_MAX) begin : g_chk_turn
    $error("soc_sram_ctrl_v2: TURN out of range");
  end

  localparam logic [CNT_W-1:0] RD_CNT   = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_CNT   = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] TURN_CNT = CNT_W'((TURN > 0) ? TURN - 1 : 0);
  localparam state_e           POST_ST  = (TURN > 0) ? ST_TURN : ST_IDLE;

  state_e              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [ADDR_W-1:0]   a_d;
  logic [DATA_W-1:0]   dout, dout_d, rdata_d;
  logic                drive, drive_d;
  logic                cen_d, oen_d, wen_d, rsp_valid_d, rsp_we_d;
  logic [BE_W-1:0]     ben_d;

  assign req_ready = (state == ST_IDLE);
  assign mem_D     = drive ? dout : {DATA_W{1'bz}};

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    a_d         = mem_A;
    dout_d      = dout;
    drive_d     = drive;
    cen_d       = mem_CEN;
    oen_d       = mem_OEN;
    wen_d       = mem_WEN;
    ben_d       = mem_BEN;
    rsp_valid_d = 1'b0;
    rsp_we_d    = rsp_we;
    rdata_d     = rsp_rdata;
    unique case (state)
      ST_IDLE: if (req_valid) begin
        a_d   = req_addr;
        cen_d = 1'b0;
        if (req_we == '0) begin
          state_d = ST_RD;
          oen_d   = 1'b0;
          wen_d   = 1'b1;
          ben_d   = '0;
          cnt_d   = RD_CNT;
        end else begin
          state_d = ST_WR;
          dout_d  = req_wdata;
          oen_d   = 1'b1;
          wen_d   = 1'b0;
          ben_d   = ~req_we;
          drive_d = 1'b1;
          cnt_d   = WR_CNT;
        end
      end
      ST_RD: if (cnt == '0) begin
        rdata_d     = mem_D;
        rsp_valid_d = 1'b1;
        rsp_we_d    = 1'b0;
        cen_d       = 1'b1;
        oen_d       = 1'b1;
        ben_d       = '1;
        state_d     = POST_ST;
        cnt_d       = TURN_CNT;
      end else begin
        cnt_d = cnt - CNT_W'(1);
      end
      // WEN rises while address, data and CEN stay put for one hold cycle.
      ST_WR: if (cnt == '0) begin
        state_d     = ST_WR_HOLD;
        wen_d       = 1'b1;
        ben_d       = '1;
        rsp_valid_d = 1'b1;
        rsp_we_d    = 1'b1;
      end else begin
        cnt_d = cnt - CNT_W'(1);
      end
      ST_WR_HOLD: begin
        cen_d   = 1'b1;
        drive_d = 1'b0;
        state_d = POST_ST;
        cnt_d   = TURN_CNT;
      end
      ST_TURN: if (cnt == '0) state_d = ST_IDLE;
               else           cnt_d   = cnt - CNT_W'(1);
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_A     <= '0;
      dout      <= '0;
      drive     <= 1'b0;
      mem_CEN   <= 1'b1;
      mem_OEN   <= 1'b1;
      mem_WEN   <= 1'b1;
      mem_BEN   <= '1;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      mem_A     <= a_d;
      dout      <= dout_d;
      drive     <= drive_d;
      mem_CEN   <= cen_d;
      mem_OEN   <= oen_d;
      mem_WEN   <= wen_d;
      mem_BEN   <= ben_d;
      rsp_valid <= rsp_valid_d;
      rsp_we    <= rsp_we_d;
      rsp_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_soc_sram_ctrl_v2.sv
// Directed bench: default-parameter controller (A) and a RD4/WR1/TURN0/16-bit one (B),
// each against a small byte-enable SRAM model.
module tb_soc_sram_ctrl_v2;

  logic clk = 1'b0;
  logic resetn;
  logic preload;
  always #5 clk = ~clk;

  // DUT A: defaults
  logic        a_valid, a_ready, a_rsp_valid, a_rsp_we, a_cen, a_oen, a_wen;
  logic [3:0]  a_we, a_ben;
  logic [19:0] a_addr, a_A;
  logic [31:0] a_wd, a_rdata;
  wire  [31:0] a_D;
  // DUT B: RD_WAIT=4, WR_WAIT=1, TURN=0, DATA_W=16
  logic        b_valid, b_ready, b_rsp_valid, b_rsp_we, b_cen, b_oen, b_wen;
  logic [1:0]  b_we, b_ben;
  logic [19:0] b_addr, b_A;
  logic [15:0] b_wd, b_rdata;
  wire  [15:0] b_D;

  soc_sram_ctrl_v2 u_a (
    .clk(clk), .resetn(resetn), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_wdata(a_wd), .rsp_valid(a_rsp_valid), .rsp_we(a_rsp_we),
    .rsp_rdata(a_rdata), .mem_A(a_A), .mem_CEN(a_cen), .mem_OEN(a_oen), .mem_WEN(a_wen),
    .mem_BEN(a_ben), .mem_D(a_D));

  soc_sram_ctrl_v2 #(.ADDR_W(20), .DATA_W(16), .RD_WAIT(4), .WR_WAIT(1), .TURN(0)) u_b (
    .clk(clk), .resetn(resetn), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wd), .rsp_valid(b_rsp_valid), .rsp_we(b_rsp_we),
    .rsp_rdata(b_rdata), .mem_A(b_A), .mem_CEN(b_cen), .mem_OEN(b_oen), .mem_WEN(b_wen),
    .mem_BEN(b_ben), .mem_D(b_D));

  // SRAM models: 256 words indexed by the low address byte
  logic [31:0] a_mem [256];
  logic [15:0] b_mem [256];
  assign a_D = (!a_cen && !a_oen) ? a_mem[a_A[7:0]] : 32'bz;
  assign b_D = (!b_cen && !b_oen) ? b_mem[b_A[7:0]] : 16'bz;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) begin
        a_mem[i] <= 32'h0;
        b_mem[i] <= 16'h0;
      end
      a_mem[8'h12] <= 32'hDEADBEEF;
      a_mem[8'h40] <= 32'hAABBCCDD;
      a_mem[8'h20] <= 32'h55667788;
      b_mem[8'h05] <= 16'hBEEF;
    end else begin
      if (!a_cen && !a_wen)
        for (int k = 0; k < 4; k++)
          if (!a_ben[k]) a_mem[a_A[7:0]][8*k +: 8] <= a_D[8*k +: 8];
      if (!b_cen && !b_wen)
        for (int k = 0; k < 2; k++)
          if (!b_ben[k]) b_mem[b_A[7:0]][8*k +: 8] <= b_D[8*k +: 8];
    end
  end

  // Free-running monitors sampled on the falling edge; tests read deltas.
  int          n_oen [2], n_wen [2], n_drv [2], n_rdylo [2], n_rsp [2];
  int          n_gap [2], n_abad [2], n_ovl [2], n_hold [2];
  logic [3:0]  ben_seen [2];
  logic [7:0]  rsp_hist [2];
  logic [19:0] exp_addr [2];
  logic [19:0] pa_A, pb_A;
  logic [3:0]  pa_ben;
  logic [1:0]  pb_ben;
  logic        pa_wen, pb_wen;

  initial begin
    for (int i = 0; i < 2; i++) begin
      n_oen[i] = 0; n_wen[i] = 0; n_drv[i] = 0; n_rdylo[i] = 0; n_rsp[i] = 0;
      n_gap[i] = 0; n_abad[i] = 0; n_ovl[i] = 0; n_hold[i] = 0;
      ben_seen[i] = 4'h0; rsp_hist[i] = 8'h0;
    end
    pa_wen = 1'b1; pb_wen = 1'b1; pa_A = '0; pb_A = '0; pa_ben = '1; pb_ben = '1;
  end

  always @(negedge clk) begin
    if (!a_oen) n_oen[0]++;
    if (!a_wen) n_wen[0]++;
    if (u_a.drive) n_drv[0]++;
    if (!a_ready) n_rdylo[0]++;
    if (!a_ready && a_cen) n_gap[0]++;
    if (!a_cen && a_A != exp_addr[0]) n_abad[0]++;
    if (!a_oen && u_a.drive) n_ovl[0]++;
    if (!a_wen && !pa_wen && (a_A != pa_A || a_ben != pa_ben)) n_hold[0]++;
    if (!a_oen || !a_wen) ben_seen[0] = a_ben;
    if (a_rsp_valid) begin n_rsp[0]++; rsp_hist[0] = {rsp_hist[0][6:0], a_rsp_we}; end
    pa_wen = a_wen; pa_A = a_A; pa_ben = a_ben;

    if (!b_oen) n_oen[1]++;
    if (!b_wen) n_wen[1]++;
    if (u_b.drive) n_drv[1]++;
    if (!b_ready) n_rdylo[1]++;
    if (!b_ready && b_cen) n_gap[1]++;
    if (!b_cen && b_A != exp_addr[1]) n_abad[1]++;
    if (!b_oen && u_b.drive) n_ovl[1]++;
    if (!b_wen && !pb_wen && (b_A != pb_A || b_ben != pb_ben)) n_hold[1]++;
    if (!b_oen || !b_wen) ben_seen[1] = {2'b00, b_ben};
    if (b_rsp_valid) begin n_rsp[1]++; rsp_hist[1] = {rsp_hist[1][6:0], b_rsp_we}; end
    pb_wen = b_wen; pb_A = b_A; pb_ben = b_ben;
  end

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          d;
    logic [3:0]  we;
    logic [19:0] addr;
    logic [31:0] wd;
    int          e_oen, e_wen, e_drv, e_rdylo, e_gap;
    logic        e_rwe;
    logic [31:0] e_rdata;
    logic [3:0]  e_ben;
  } vec_t;

  task automatic set_req(input int d, input logic v, input logic [3:0] we,
                         input logic [19:0] addr, input logic [31:0] wd);
    if (d == 0) begin a_valid = v; a_we = we; a_addr = addr; a_wd = wd; end
    else begin b_valid = v; b_we = we[1:0]; b_addr = addr; b_wd = wd[15:0]; end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int d = v.d;
    int o0 = n_oen[d], w0 = n_wen[d], dr0 = n_drv[d], r0 = n_rdylo[d];
    int g0 = n_gap[d], s0 = n_rsp[d];
    int t = 0;
    logic rdy;
    @(negedge clk);
    exp_addr[d] = v.addr;
    set_req(d, 1'b1, v.we, v.addr, v.wd);
    @(negedge clk);
    set_req(d, 1'b0, 4'h0, 20'h0, 32'h0);
    rdy = d ? b_ready : a_ready;
    while (!rdy && t < 50) begin
      @(negedge clk);
      t++;
      rdy = d ? b_ready : a_ready;
    end
    chk($sformatf("v%0d ready-return", idx), 32'(t < 50), 32'd1);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d oen-low", idx), 32'(n_oen[d] - o0), 32'(v.e_oen));
    chk($sformatf("v%0d wen-low", idx), 32'(n_wen[d] - w0), 32'(v.e_wen));
    chk($sformatf("v%0d drive", idx), 32'(n_drv[d] - dr0), 32'(v.e_drv));
    chk($sformatf("v%0d ready-low", idx), 32'(n_rdylo[d] - r0), 32'(v.e_rdylo));
    chk($sformatf("v%0d turn-gap", idx), 32'(n_gap[d] - g0), 32'(v.e_gap));
    chk($sformatf("v%0d rsp-count", idx), 32'(n_rsp[d] - s0), 32'd1);
    chk($sformatf("v%0d rsp-we", idx), 32'(rsp_hist[d][0]), 32'(v.e_rwe));
    chk($sformatf("v%0d rdata", idx), d ? {16'h0, b_rdata} : a_rdata, v.e_rdata);
    chk($sformatf("v%0d ben", idx), 32'(ben_seen[d]), 32'(v.e_ben));
  endtask

  vec_t vecs [10];

  initial begin
    int s_rsp, s_oen, s_wen, s_gap, s_ovl, s_abad, t;

    //        d  we     addr        wdata          oen wen drv rlo gap rwe rdata          ben
    vecs[0] = '{0, 4'h0, 20'h00012, 32'h0,          2,  0,  0,  3,  1,  1'b0, 32'hDEADBEEF, 4'h0};
    vecs[1] = '{0, 4'h5, 20'h00040, 32'h11223344,   0,  2,  3,  4,  1,  1'b1, 32'hDEADBEEF, 4'hA};
    vecs[2] = '{0, 4'h0, 20'h00040, 32'h0,          2,  0,  0,  3,  1,  1'b0, 32'hAA22CC44, 4'h0};
    vecs[3] = '{0, 4'hF, 20'hFFFFF, 32'hCAFEF00D,   0,  2,  3,  4,  1,  1'b1, 32'hAA22CC44, 4'h0};
    vecs[4] = '{0, 4'h0, 20'hFFFFF, 32'h0,          2,  0,  0,  3,  1,  1'b0, 32'hCAFEF00D, 4'h0};
    vecs[5] = '{0, 4'h8, 20'h00012, 32'h12345678,   0,  2,  3,  4,  1,  1'b1, 32'hCAFEF00D, 4'h7};
    vecs[6] = '{0, 4'h0, 20'h00012, 32'h0,          2,  0,  0,  3,  1,  1'b0, 32'h12ADBEEF, 4'h0};
    vecs[7] = '{1, 4'h0, 20'h00005, 32'h0,          4,  0,  0,  4,  0,  1'b0, 32'h0000BEEF, 4'h0};
    vecs[8] = '{1, 4'h2, 20'h00005, 32'h00001234,   0,  1,  2,  2,  0,  1'b1, 32'h0000BEEF, 4'h1};
    vecs[9] = '{1, 4'h0, 20'h00005, 32'h0,          4,  0,  0,  4,  0,  1'b0, 32'h000012EF, 4'h0};

    exp_addr[0] = '0; exp_addr[1] = '0;
    set_req(0, 1'b0, 4'h0, 20'h0, 32'h0);
    set_req(1, 1'b0, 4'h0, 20'h0, 32'h0);
    preload = 1'b1;
    resetn  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    resetn  = 1'b1;
    #1;
    chk("reset ready", 32'(a_ready), 32'd1);
    chk("reset strobes", {29'h0, a_cen, a_oen, a_wen}, 32'h7);
    chk("reset ben", 32'(a_ben), 32'hF);
    chk("reset mem_A", 32'(a_A), 32'h0);
    chk("reset rsp", {30'h0, a_rsp_valid, a_rsp_we}, 32'h0);
    chk("reset B ready", 32'(b_ready), 32'd1);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Write then read with req_valid held high throughout
    s_rsp = n_rsp[0]; s_oen = n_oen[0]; s_wen = n_wen[0]; s_gap = n_gap[0]; s_ovl = n_ovl[0];
    @(negedge clk);
    exp_addr[0] = 20'h00020;
    set_req(0, 1'b1, 4'h3, 20'h00020, 32'hABCD1234);
    @(negedge clk);
    set_req(0, 1'b1, 4'h0, 20'h00020, 32'h0);
    t = 0;
    while (a_oen && t < 40) begin @(negedge clk); t++; end
    a_valid = 1'b0;
    chk("b2b read-accept", 32'(t < 40), 32'd1);
    t = 0;
    while (!a_ready && t < 40) begin @(negedge clk); t++; end
    chk("b2b ready-return", 32'(t < 40), 32'd1);
    @(negedge clk);
    #1;
    chk("b2b rsp-count", 32'(n_rsp[0] - s_rsp), 32'd2);
    chk("b2b rsp-order", 32'(rsp_hist[0][1:0]), 32'h2);
    chk("b2b overlap", 32'(n_ovl[0] - s_ovl), 32'd0);
    chk("b2b turn-gap", 32'(n_gap[0] - s_gap), 32'd2);
    chk("b2b oen-low", 32'(n_oen[0] - s_oen), 32'd2);
    chk("b2b wen-low", 32'(n_wen[0] - s_wen), 32'd2);
    chk("b2b rdata", a_rdata, 32'h55661234);

    // Asynchronous reset in WR with one cycle left on the counter
    s_rsp = n_rsp[0];
    @(negedge clk);
    exp_addr[0] = 20'h00030;
    set_req(0, 1'b1, 4'hF, 20'h00030, 32'h0BADF00D);
    @(negedge clk);
    set_req(0, 1'b0, 4'h0, 20'h0, 32'h0);
    chk("pre-reset wen", 32'(a_wen), 32'd0);
    #2 resetn = 1'b0;
    #1;
    chk("mid-reset strobes", {29'h0, a_cen, a_oen, a_wen}, 32'h7);
    chk("mid-reset ben", 32'(a_ben), 32'hF);
    chk("mid-reset drive", 32'(u_a.drive), 32'd0);
    chk("mid-reset ready", 32'(a_ready), 32'd1);
    chk("mid-reset rdata", a_rdata, 32'h0);
    chk("mid-reset mem_A", 32'(a_A), 32'h0);
    @(negedge clk);
    #2 resetn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post-reset rsp-count", 32'(n_rsp[0] - s_rsp), 32'd0);
    chk("post-reset ready", 32'(a_ready), 32'd1);

    // Request fields wiggled while the controller is busy
    s_rsp = n_rsp[0]; s_oen = n_oen[0]; s_wen = n_wen[0]; s_abad = n_abad[0];
    @(negedge clk);
    exp_addr[0] = 20'h00012;
    set_req(0, 1'b1, 4'h0, 20'h00012, 32'h0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (!a_ready)
        set_req(0, ~a_valid, (t % 2) ? 4'hF : 4'h0, 20'h00012 + 20'(t * 'h111), 32'h600D0000 + 32'(t));
    end while (!a_ready && t < 40);
    a_valid = 1'b0;
    chk("busy ready-return", 32'(t < 40), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("busy rsp-count", 32'(n_rsp[0] - s_rsp), 32'd1);
    chk("busy oen-low", 32'(n_oen[0] - s_oen), 32'd2);
    chk("busy wen-low", 32'(n_wen[0] - s_wen), 32'd0);
    chk("busy addr-stable", 32'(n_abad[0] - s_abad), 32'd0);
    chk("busy rdata", a_rdata, 32'h12ADBEEF);

    chk("A oen/drive overlap", 32'(n_ovl[0]), 32'd0);
    chk("B oen/drive overlap", 32'(n_ovl[1]), 32'd0);
    chk("A addr/ben move under WEN", 32'(n_hold[0]), 32'd0);
    chk("B addr/ben move under WEN", 32'(n_hold[1]), 32'd0);
    chk("B addr-stable", 32'(n_abad[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/soc_sram_ctrl_v2.md
# soc_sram_ctrl_v2

Parametrised asynchronous-SRAM controller between the SoC memory-side valid/ready request port and an external asynchronous SRAM chip (CEN/OEN/WEN/byte-enable, shared bidirectional data bus). Generalises the fixed 20-bit/32-bit, fixed-phase controller with configurable address/data width, read and write strobe lengths, a write data-hold cycle and bus-turnaround cycles. Every request returns an explicit one-cycle response. All SRAM pins are driven directly from flops.

## Interface
- ADDR_W, 20: SRAM word-address width.
- DATA_W, 32: data width. Must be a multiple of 8. BE_W = DATA_W/8.
- RD_WAIT, 2: cycles OEN is held low before the data sample. Range 1..16.
- WR_WAIT, 2: cycles WEN is held low. Range 1..16.
- TURN, 1: idle bus-turnaround cycles after every access. Range 0..15.
- clk  in  1  single clock.
- resetn  in  1  reset. Asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts the request this cycle.
- req_we  in  BE_W  byte write enables. All zero means read; any bit set means write.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_we  out  1  1 means the completed access was a write.
- rsp_rdata  out  DATA_W  read data. Valid while rsp_valid && !rsp_we. Held afterwards.
- mem_A  out  ADDR_W  SRAM address.
- mem_CEN, mem_OEN, mem_WEN  out  1 each  active-low strobes.
- mem_BEN  out  BE_W  active-low byte enables.
- mem_D  inout  DATA_W  data bus. Driven only while write-drive is set; Z otherwise.

## Operation
- States: IDLE, RD, WR, WR_HOLD, TURN. A down-counter cnt is wide enough for 16.
- IDLE:
  - req_ready=1.
  - On req_valid with req_we==0, go to RD. Register mem_A=req_addr, CEN=0, OEN=0, WEN=1, BEN=all 0. Set cnt=RD_WAIT-1.
  - On req_valid with req_we!=0, go to WR. Register mem_A, Dout=req_wdata, CEN=0, OEN=1, WEN=0, BEN=~req_we, drive=1. Set cnt=WR_WAIT-1.
- RD:
  - Decrement cnt.
  - At cnt==0: capture mem_D into rsp_rdata, pulse rsp_valid with rsp_we=0, set CEN=OEN=1 and BEN=all 1.
  - Then go to TURN if TURN>0, else IDLE.
- WR:
  - Decrement cnt.
  - At cnt==0: go to WR_HOLD. Set WEN=1 and BEN=all 1. Keep CEN=0, mem_A and drive unchanged. Pulse rsp_valid with rsp_we=1.
- WR_HOLD: one cycle. Then CEN=1, drive=0, and go to TURN or IDLE.
- TURN:
  - TURN cycles with all strobes high, bus released, req_ready=0.
  - Then go to IDLE.
- req_ready is high only in IDLE, so requests are never accepted mid-access.
- A request whose fields change while req_ready=0 has no effect.
- Reset (asynchronous, any state, mid-access included) forces:
  - state=IDLE, CEN=OEN=WEN=1, BEN=all 1, drive=0.
  - mem_A=0, Dout=0, rsp_rdata=0.
  - rsp_valid=0, rsp_we=0, cnt=0.
  - An interrupted access produces no response. The first cycle after deassertion is IDLE with req_ready=1.

## Timing
- Handshake sampled at edge k.
- Read:
  - Strobes low from edge k to edge k+RD_WAIT.
  - mem_D is sampled at edge k+RD_WAIT; rsp_valid is high for the following cycle.
  - req_ready returns after edge k+RD_WAIT+TURN.
- Write:
  - WEN low from edge k to edge k+WR_WAIT.
  - Data, address and CEN are held until edge k+WR_WAIT+1.
  - rsp_valid is high in the hold cycle.
  - req_ready returns after edge k+WR_WAIT+1+TURN.
- Back-to-back minimum period: RD_WAIT+TURN+1 cycles (read), WR_WAIT+TURN+2 cycles (write).
- mem_A and the byte enables never change while WEN=0.
- OEN and drive are never both active in the same cycle.

## Structure
- Package soc_sram_pkg holds:
  - state encoding localparams;
  - the BE_W derivation;
  - parameter range-check constants.
- Elaboration-time checks reject DATA_W%8!=0 and any out-of-range RD_WAIT, WR_WAIT or TURN.
- Single module. No sub-module is needed; the wait counter is inline.

## Test plan
- Reset, then read at 0x00012, SRAM model returns 0xDEADBEEF (defaults) -> OEN low 2 cycles, rsp_valid 1 cycle with rsp_rdata=0xDEADBEEF, req_ready low 3 cycles.
- Write req_we=4'b0101, data 0x11223344 to 0x00040 -> WEN low 2 cycles, mem_BEN=4'b1010, data driven 3 cycles, then readback returns 0xXX22XX44 merged with the prior contents.
- Write immediately followed by read (req_valid held high) -> no cycle with OEN=0 and the bus driven; TURN=1 gap observed; both responses returned in order.
- RD_WAIT=4, WR_WAIT=1, TURN=0, DATA_W=16 -> OEN low exactly 4 cycles, WEN low 1 cycle, BE_W=2, zero idle cycles before req_ready.
- resetn pulsed low during WR with cnt=1 -> immediately all strobes=1, mem_D=Z, no rsp_valid, req_ready=1 after release.
- req_valid toggled with changing address while req_ready=0 -> no extra accesses and mem_A unchanged.
